// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared constants and types for the register file write arbiter
package regfile_arb_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] R15_ADDR = 4'd15;
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;
    typedef enum logic {REQ_A, REQ_B} req_id_t;
endpackage

// File: rtl/regfile_wr_fifo.sv
// regfile_wr_fifo: pending-write buffer with the head always at entry 0
module regfile_wr_fifo
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_entry,
    input  logic                   pop,
    output logic [CNT_W-1:0]       count,
    output entry_t [DEPTH-1:0]     entries
);
    logic [CNT_W-1:0] count_q, count_d, base;
    entry_t [DEPTH-1:0] entries_q, entries_d;
    always_comb begin
        entries_d = entries_q;
        for (int i = 0; i < DEPTH - 1; i++) entries_d[i] = pop ? entries_q[i + 1] : entries_q[i];
        base = pop ? count_q - 1'b1 : count_q;
        for (int i = 0; i < DEPTH; i++) if (push && base == CNT_W'(i)) entries_d[i] = push_entry;
        count_d = base + CNT_W'(push);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            entries_q <= '0;
        end else begin
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end
    assign count   = count_q;
    assign entries = entries_q;
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin merge of two writeback requesters into one register file write port
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [3:0]       a_addr,
    input  logic [WIDTH-1:0] a_data,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [3:0]       b_addr,
    input  logic [WIDTH-1:0] b_data,
    output logic             b_ready,
    input  logic             wr_stall,
    output logic             we3,
    output logic [3:0]       wa3,
    output logic [WIDTH-1:0] wd3,
    output logic [15:0]      busy,
    output logic             err_r15
);
    logic [CNT_W-1:0] count;
    entry_t [DEPTH-1:0] entries;
    entry_t push_entry;
    req_id_t prio_q, prio_d;
    logic err_r15_q, err_r15_d;
    logic full, accept, push, pop;
    always_comb begin
        full            = count == CNT_W'(DEPTH);
        a_ready         = !full && a_valid && (!b_valid || prio_q == REQ_A);
        b_ready         = !full && b_valid && (!a_valid || prio_q == REQ_B);
        accept          = a_ready || b_ready;
        push_entry.addr = a_ready ? a_addr : b_addr;
        push_entry.data = DATA_W'(a_ready ? a_data : b_data);
        push            = accept && push_entry.addr != R15_ADDR;
        pop             = count != '0 && !wr_stall;
        prio_d          = a_ready ? REQ_B : b_ready ? REQ_A : prio_q;
        err_r15_d       = err_r15_q || (accept && push_entry.addr == R15_ADDR);
        we3             = pop;
        wa3             = count != '0 ? entries[0].addr : '0;
        wd3             = count != '0 ? WIDTH'(entries[0].data) : '0;
        busy            = '0;
        for (int i = 0; i < DEPTH; i++) busy = busy | (CNT_W'(i) < count ? 16'd1 << entries[i].addr : 16'd0);
        err_r15         = err_r15_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q    <= REQ_A;
            err_r15_q <= 1'b0;
        end else begin
            prio_q    <= prio_d;
            err_r15_q <= err_r15_d;
        end
    end
    regfile_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (count),
        .entries    (entries)
    );
endmodule
